hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter: MD_TIMEOUT, default 63, maximum MD_BUSY cycles before abort (1..255).
REQ-002 Parameter: CNT_W, default 16, stall-counter width.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 Port: Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in Execute.
REQ-007 Port: RdM, RdW  in  5 each  destinations in Memory and Writeback.
REQ-008 Port: RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-009 Port: ResultSrcE  in  1  Execute instruction is a load.
REQ-010 Port: MissPredictionE  in  1  branch in Execute mispredicted.
REQ-011 Port: MulDivStartE  in  1  multi-cycle mul/div op present in Execute.
REQ-012 Port: MulDivDoneE  in  1  mul/div unit result valid this cycle.
REQ-013 Port: ForwardAE, ForwardBE  out  2 each  operand mux selects: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-014 Port: StallF, StallD, StallE  out  1 each  hold PC, Decode register, Execute register.
REQ-015 Port: FlushD, FlushE  out  1 each  zero the Decode or Execute register next edge.
REQ-016 Port: BubbleM  out  1  force RegWrite/MemWrite low into Memory.
REQ-017 Port: MdBusy  out  1  FSM in MD_BUSY.
REQ-018 Port: MdTimeout  out  1  sticky mul/div timeout error.
REQ-019 Port: StallCount  out  CNT_W  saturating count of cycles with StallF high.

Function
REQ-020 ForwardAE SHALL be 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00 (Memory wins over Writeback).
REQ-021 ForwardBE SHALL follow REQ-020 with Rs2E in place of Rs1E.
REQ-022 Forward selects SHALL be combinational and independent of FSM state.
REQ-023 lwStall SHALL be ResultSrcE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-024 FSM states SHALL be IDLE and MD_BUSY; reset state IDLE.
REQ-025 IDLE, MissPredictionE=1: FlushD=1, FlushE=1, all stalls 0; lwStall and MulDivStartE ignored; stay IDLE.
REQ-026 IDLE, no mispredict, lwStall=1: StallF=1, StallD=1, FlushE=1, StallE=0.
REQ-027 IDLE, no mispredict, MulDivStartE=1, MulDivDoneE=0: StallF/D/E=1, BubbleM=1; next state MD_BUSY, busy counter loaded with 1.
REQ-028 IDLE, MulDivStartE=1 with MulDivDoneE=1 same cycle: no stall, stay IDLE (single-cycle op).
REQ-029 MD_BUSY, MulDivDoneE=0: StallF/D/E=1, BubbleM=1, MdBusy=1; busy counter increments.
REQ-030 MD_BUSY, MulDivDoneE=1: stalls and BubbleM deasserted that cycle, MdBusy=1; next state IDLE.
REQ-031 MD_BUSY with busy counter==MD_TIMEOUT and no Done: stalls deasserted that cycle, MdTimeout set, next IDLE.
REQ-032 In MD_BUSY, lwStall and MissPredictionE SHALL be ignored (re-evaluated after release).
REQ-033 MdTimeout SHALL remain 1 until reset.
REQ-034 StallCount SHALL increment by 1 each cycle StallF=1 and hold at all-ones.
REQ-035 Outputs other than MdBusy, MdTimeout, StallCount SHALL be combinational from inputs and state.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, busy counter 0, MdTimeout 0, StallCount 0, MdBusy 0.
REQ-037 With all inputs 0 during or after reset, every output SHALL be 0.
REQ-038 Reset asserted in MD_BUSY SHALL abort the operation with stalls released the same instant.

Verification
REQ-039 RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00.
REQ-040 ResultSrcE=1, RdE=7, Rs2D=7 -> StallF=1, StallD=1, FlushE=1, StallCount 0->1 next edge.
REQ-041 lwStall plus MissPredictionE same cycle -> FlushD=1, FlushE=1, StallF=0.
REQ-042 MulDivStartE pulse, MulDivDoneE after 4 MD_BUSY cycles -> stalls high 5 cycles total, low on Done cycle, MdBusy falls next edge.
REQ-043 MulDivStartE, no Done, MD_TIMEOUT=8 -> release after cycle with counter 8, MdTimeout=1 held until rst_n low.
REQ-044 rst_n low mid-MD_BUSY -> MdBusy=0, stalls 0, StallCount=0 without clock edge.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard unit bundle: register tags and control inputs, plus forward/stall/flush outputs.
// The pipeline side drives the master modport; the hazard controller sits on the slave modport.
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             ResultSrcE, MissPredictionE, MulDivStartE, MulDivDoneE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, BubbleM;
  logic             MdBusy, MdTimeout;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, MissPredictionE, MulDivStartE, MulDivDoneE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           BubbleM, MdBusy, MdTimeout, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, MissPredictionE, MulDivStartE, MulDivDoneE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           BubbleM, MdBusy, MdTimeout, StallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: operand forwarding, load-use stall, mispredict flush,
// and a two-state FSM that freezes the pipe while a multi-cycle mul/div runs.
module hazard_controller #(
  parameter int unsigned MD_TIMEOUT = 63,
  parameter int unsigned CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  hazard_controller_if.slave hz
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t           state_q, state_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lw_stall;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs))
      fwd_sel = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E);

  assign lw_stall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    bubble_m   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.MissPredictionE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lw_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end else if (hz.MulDivStartE && !hz.MulDivDoneE) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_e    = 1'b1;
          bubble_m   = 1'b1;
          state_d    = MD_BUSY;
          busy_cnt_d = 8'd1;
        end
      end
      MD_BUSY: begin
        // Done takes precedence over the timeout check on the same cycle.
        if (hz.MulDivDoneE) begin
          state_d    = IDLE;
          busy_cnt_d = '0;
        end else if (busy_cnt_q == 8'(MD_TIMEOUT)) begin
          state_d    = IDLE;
          busy_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          stall_e    = 1'b1;
          bubble_m   = 1'b1;
          busy_cnt_d = busy_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.BubbleM    = bubble_m;
  assign hz.MdBusy     = (state_q == MD_BUSY);
  assign hz.MdTimeout  = timeout_q;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, mispredict, mul/div busy,
// timeout and asynchronous reset, with a narrow stall counter to reach saturation.
module tb_hazard_controller;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_controller #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
    bus.RdE = '0; bus.RdM = '0; bus.RdW = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.ResultSrcE = 1'b0; bus.MissPredictionE = 1'b0;
    bus.MulDivStartE = 1'b0; bus.MulDivDoneE = 1'b0;
  endtask

  // {StallF, StallD, StallE, FlushD, FlushE, BubbleM}
  function automatic logic [31:0] ctl();
    ctl = {26'd0, bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.BubbleM};
  endfunction

  function automatic logic [31:0] all_outs();
    all_outs = {16'd0, bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE,
                bus.FlushD, bus.FlushE, bus.BubbleM, bus.MdBusy, bus.MdTimeout, bus.StallCount};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clr();
    #2;
    chk("reset_all_zero", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle_zero", all_outs(), 32'd0);

    // Memory wins over Writeback
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
    bus.Rs1E = 5'd5; bus.Rs2E = 5'd0;
    #1;
    chk("fwdA_mem_priority", 32'(bus.ForwardAE), 32'd2);
    chk("fwdB_none", 32'(bus.ForwardBE), 32'd0);
    clr();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd3; bus.Rs2E = 5'd3; bus.RdM = 5'd3;
    #1;
    chk("fwdB_wb", 32'(bus.ForwardBE), 32'd1);
    clr();
    bus.RegWriteM = 1'b1; bus.RdM = 5'd0; bus.Rs1E = 5'd0;
    #1;
    chk("fwdA_x0_blocked", 32'(bus.ForwardAE), 32'd0);
    clr();

    // load-use stall
    bus.ResultSrcE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1;
    chk("lw_ctl", ctl(), 32'b110010);
    chk("lw_cnt_before", 32'(bus.StallCount), 32'd0);
    tick();
    chk("lw_cnt_after", 32'(bus.StallCount), 32'd1);
    clr();
    bus.ResultSrcE = 1'b1; bus.RdE = 5'd0; bus.Rs1D = 5'd0;
    #1;
    chk("lw_rd0_no_stall", ctl(), 32'd0);
    clr();

    // mispredict beats load-use
    bus.ResultSrcE = 1'b1; bus.RdE = 5'd9; bus.Rs1D = 5'd9; bus.MissPredictionE = 1'b1;
    #1;
    chk("miss_over_lw", ctl(), 32'b000110);
    tick();
    clr();

    // single-cycle mul/div
    bus.MulDivStartE = 1'b1; bus.MulDivDoneE = 1'b1;
    #1;
    chk("md_single_cycle", ctl(), 32'd0);
    tick();
    clr();
    #1;
    chk("md_single_no_busy", 32'(bus.MdBusy), 32'd0);
    chk("cnt_still_1", 32'(bus.StallCount), 32'd1);

    // mul/div finishing after 4 busy cycles
    bus.MulDivStartE = 1'b1;
    #1;
    chk("md_start_ctl", ctl(), 32'b111001);
    chk("md_start_busy0", 32'(bus.MdBusy), 32'd0);
    tick();
    bus.MulDivStartE = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        bus.MissPredictionE = 1'b1; bus.ResultSrcE = 1'b1; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
      end
      #1;
      chk($sformatf("md_busy_ctl_%0d", i), ctl(), 32'b111001);
      chk($sformatf("md_busy_flag_%0d", i), 32'(bus.MdBusy), 32'd1);
      tick();
      clr();
    end
    bus.MulDivDoneE = 1'b1;
    #1;
    chk("md_done_ctl", ctl(), 32'd0);
    chk("md_done_busy1", 32'(bus.MdBusy), 32'd1);
    tick();
    clr();
    #1;
    chk("md_done_busy_falls", 32'(bus.MdBusy), 32'd0);
    chk("cnt_after_md", 32'(bus.StallCount), 32'd6);

    // timeout at counter 8
    bus.MulDivStartE = 1'b1;
    tick();
    bus.MulDivStartE = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      chk($sformatf("to_busy_ctl_%0d", i), ctl(), 32'b111001);
      tick();
    end
    #1;
    chk("to_release_ctl", ctl(), 32'd0);
    chk("to_release_busy", 32'(bus.MdBusy), 32'd1);
    chk("to_not_yet_flag", 32'(bus.MdTimeout), 32'd0);
    tick();
    chk("to_flag_set", 32'(bus.MdTimeout), 32'd1);
    chk("to_idle", 32'(bus.MdBusy), 32'd0);
    chk("cnt_after_to", 32'(bus.StallCount), 32'd14);
    tick();
    tick();
    chk("to_flag_sticky", 32'(bus.MdTimeout), 32'd1);

    // stall counter saturation
    bus.ResultSrcE = 1'b1; bus.RdE = 5'd2; bus.Rs1D = 5'd2;
    tick();
    chk("cnt_15", 32'(bus.StallCount), 32'd15);
    tick();
    chk("cnt_saturated", 32'(bus.StallCount), 32'd15);
    clr();

    // async reset mid MD_BUSY
    bus.MulDivStartE = 1'b1;
    tick();
    bus.MulDivStartE = 1'b0;
    #1;
    chk("pre_rst_busy", 32'(bus.MdBusy), 32'd1);
    chk("pre_rst_ctl", ctl(), 32'b111001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", ctl(), 32'd0);
    chk("rst_mid_busy", 32'(bus.MdBusy), 32'd0);
    chk("rst_mid_cnt", 32'(bus.StallCount), 32'd0);
    chk("rst_mid_timeout", 32'(bus.MdTimeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("final_idle", all_outs(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
